// File: rtl/gpr_file_sb.sv
// -----------------------------------------------------------------------------
// gpr_file_sb
// General-purpose register file with a busy scoreboard for the processor core.
// Sits between decode (read/destination fields, hazard stall) and writeback
// (result bus, write enable).
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous active-high reset
//   regWr      - write enable for busW into the selected destination Rw
//   Rs, Rt     - read addresses for ports A and B (Rt is also the alt. dest)
//   Rd         - primary destination
//   Rdst       - destination select: 0 = Rt, 1 = Rd
//   jal_instr  - forces the destination to LINK_REG, overrides Rdst
//   busW       - write data
//   mark_busy  - marks mark_addr as awaiting a pending result
//   mark_addr  - register to mark busy
//   busA, busB - registered read data for ports A and B
//   stall      - combinational hazard flag for the current Rs/Rt
//   busy_vec   - scoreboard bits, for debug
// -----------------------------------------------------------------------------
module gpr_file_sb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = 2**ADDR_W - 1,
    parameter int ZERO_REG_EN = 1,
    parameter int BYPASS_EN   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   regWr,
    input  logic [ADDR_W-1:0]      Rs,
    input  logic [ADDR_W-1:0]      Rt,
    input  logic [ADDR_W-1:0]      Rd,
    input  logic                   Rdst,
    input  logic                   jal_instr,
    input  logic [DATA_W-1:0]      busW,
    input  logic                   mark_busy,
    input  logic [ADDR_W-1:0]      mark_addr,
    output logic [DATA_W-1:0]      busA,
    output logic [DATA_W-1:0]      busB,
    output logic                   stall,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int                NREG      = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic              ZERO_ON   = (ZERO_REG_EN != 0);
    localparam logic              BYP_ON    = (BYPASS_EN != 0);

    logic [DATA_W-1:0] reg_file_r [NREG];
    logic [NREG-1:0]   busy_r;
    logic [DATA_W-1:0] bus_a_r;
    logic [DATA_W-1:0] bus_b_r;

    logic [ADDR_W-1:0] rw_s;
    logic              wr_en_s;
    logic              mark_ok_s;
    logic              byp_a_s;
    logic              byp_b_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;
    logic [NREG-1:0]   busy_nxt_s;

    // Destination select: jal overrides Rdst.
    always_comb begin
        if (jal_instr) begin
            rw_s = LINK_ADDR;
        end else if (Rdst) begin
            rw_s = Rd;
        end else begin
            rw_s = Rt;
        end
    end

    // Effective write and mark qualifiers; register 0 swallows both when hardwired.
    always_comb begin
        wr_en_s   = regWr & ~(ZERO_ON & (rw_s == ZERO_ADDR));
        mark_ok_s = mark_busy & ~(ZERO_ON & (mark_addr == ZERO_ADDR));
    end

    // Bypass hits use the raw regWr: a dropped write to r0 never matters because
    // r0 reads as zero and is never busy in that configuration.
    always_comb begin
        byp_a_s = BYP_ON & regWr & (rw_s == Rs);
        byp_b_s = BYP_ON & regWr & (rw_s == Rt);
    end

    // Read-value selection for port A: zero register, bypass, then stored value.
    always_comb begin
        rd_a_s = reg_file_r[Rs];
        if (ZERO_ON && (Rs == ZERO_ADDR)) begin
            rd_a_s = {DATA_W{1'b0}};
        end else if (byp_a_s) begin
            rd_a_s = busW;
        end else begin
            rd_a_s = reg_file_r[Rs];
        end
    end

    // Read-value selection for port B: zero register, bypass, then stored value.
    always_comb begin
        rd_b_s = reg_file_r[Rt];
        if (ZERO_ON && (Rt == ZERO_ADDR)) begin
            rd_b_s = {DATA_W{1'b0}};
        end else if (byp_b_s) begin
            rd_b_s = busW;
        end else begin
            rd_b_s = reg_file_r[Rt];
        end
    end

    // Scoreboard next state: clear on a performed write, then set on mark so a
    // same-edge collision leaves the register busy for the new producer.
    always_comb begin
        busy_nxt_s            = busy_r;
        busy_nxt_s[rw_s]      = busy_r[rw_s] & ~wr_en_s;
        busy_nxt_s[mark_addr] = busy_nxt_s[mark_addr] | mark_ok_s;
        busy_nxt_s[0]         = busy_nxt_s[0] & ~ZERO_ON;
    end

    // Hazard: a busy source stalls unless its producer is being bypassed right now.
    always_comb begin
        stall = (busy_r[Rs] & ~byp_a_s) | (busy_r[Rt] & ~byp_b_s);
    end

    // Register array storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                reg_file_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            reg_file_r[rw_s] <= busW;
        end
    end

    // Registered read ports and scoreboard state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_a_r <= {DATA_W{1'b0}};
            bus_b_r <= {DATA_W{1'b0}};
            busy_r  <= {NREG{1'b0}};
        end else begin
            bus_a_r <= rd_a_s;
            bus_b_r <= rd_b_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign busA     = bus_a_r;
    assign busB     = bus_b_r;
    assign busy_vec = busy_r;

endmodule

// File: tb/tb_gpr_file_sb.sv
// -----------------------------------------------------------------------------
// tb_gpr_file_sb
// Scoreboard bench for gpr_file_sb. Three instances: default (bypass on),
// bypass off (same inputs as the default one), and a 64-bit x 16 variant.
// Stimulus pushes expected values tagged with the cycle in which they must be
// visible; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_gpr_file_sb;

    logic        clk = 1'b0;
    logic        reset;

    // shared inputs for instances a (bypass) and b (no bypass)
    logic        regWr, Rdst, jal_instr, mark_busy;
    logic [4:0]  Rs, Rt, Rd, mark_addr;
    logic [31:0] busW;
    logic [31:0] busA_a, busB_a, busA_b, busB_b, bv_a, bv_b;
    logic        stall_a, stall_b;

    // inputs for the 64-bit / 16-register instance
    logic        regwr_c, rdst_c, jal_c, mark_c;
    logic [3:0]  rs_c, rt_c, rd_c, maddr_c;
    logic [63:0] busw_c, busA_c, busB_c;
    logic [15:0] bv_c;
    logic        stall_c;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          when;
        int          dut;
        int          sel;   // 0 busA, 1 busB, 2 stall, 3 busy bit idx, 4 busy_vec
        int          idx;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];

    gpr_file_sb u_a (
        .clk(clk), .reset(reset), .regWr(regWr), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .Rdst(Rdst), .jal_instr(jal_instr), .busW(busW), .mark_busy(mark_busy),
        .mark_addr(mark_addr), .busA(busA_a), .busB(busB_a), .stall(stall_a),
        .busy_vec(bv_a)
    );

    gpr_file_sb #(.BYPASS_EN(0)) u_b (
        .clk(clk), .reset(reset), .regWr(regWr), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .Rdst(Rdst), .jal_instr(jal_instr), .busW(busW), .mark_busy(mark_busy),
        .mark_addr(mark_addr), .busA(busA_b), .busB(busB_b), .stall(stall_b),
        .busy_vec(bv_b)
    );

    gpr_file_sb #(.DATA_W(64), .ADDR_W(4), .LINK_REG(15)) u_c (
        .clk(clk), .reset(reset), .regWr(regwr_c), .Rs(rs_c), .Rt(rt_c), .Rd(rd_c),
        .Rdst(rdst_c), .jal_instr(jal_c), .busW(busw_c), .mark_busy(mark_c),
        .mark_addr(maddr_c), .busA(busA_c), .busB(busB_c), .stall(stall_c),
        .busy_vec(bv_c)
    );

    always #5 clk = ~clk;

    // cycle stamp: value k holds from rising edge k until rising edge k+1
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(int dut, int sel, int idx);
        logic [63:0] a, b, bv;
        logic        s;
        case (dut)
            0:       begin a = 64'(busA_a); b = 64'(busB_a); bv = 64'(bv_a); s = stall_a; end
            1:       begin a = 64'(busA_b); b = 64'(busB_b); bv = 64'(bv_b); s = stall_b; end
            default: begin a = busA_c;      b = busB_c;      bv = 64'(bv_c); s = stall_c; end
        endcase
        case (sel)
            0:       return a;
            1:       return b;
            2:       return {63'd0, s};
            3:       return {63'd0, bv[idx]};
            default: return bv;
        endcase
    endfunction

    task automatic push(int when, int dut, int sel, int idx, logic [63:0] v, string nm);
        chk_t c;
        c.when = when; c.dut = dut; c.sel = sel; c.idx = idx; c.exp = v; c.name = nm;
        q.push_back(c);
    endtask

    // same expectation point on the bypass and no-bypass instances
    task automatic push2(int when, int sel, int idx, logic [63:0] va, logic [63:0] vb, string nm);
        push(when, 0, sel, idx, va, {nm, "_a"});
        push(when, 1, sel, idx, vb, {nm, "_b"});
    endtask

    // monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        int i;
        logic [63:0] act;
        i = 0;
        while (i < q.size()) begin
            if (q[i].when <= cyc) begin
                act = actual(q[i].dut, q[i].sel, q[i].idx);
                checks++;
                if (act !== q[i].exp) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %0h, expected %0h",
                             q[i].name, cyc, act, q[i].exp);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    // advance to just after the next rising edge and return inputs to idle
    task automatic tick();
        @(posedge clk);
        #1;
        regWr = 1'b0; Rdst = 1'b1; jal_instr = 1'b0; mark_busy = 1'b0;
        Rs = 5'd0; Rt = 5'd0; Rd = 5'd0; mark_addr = 5'd0; busW = 32'd0;
        regwr_c = 1'b0; rdst_c = 1'b1; jal_c = 1'b0; mark_c = 1'b0;
        rs_c = 4'd0; rt_c = 4'd0; rd_c = 4'd0; maddr_c = 4'd0; busw_c = 64'd0;
    endtask

    initial begin
        reset = 1'b1;
        regWr = 1'b0; Rdst = 1'b1; jal_instr = 1'b0; mark_busy = 1'b0;
        Rs = 5'd0; Rt = 5'd0; Rd = 5'd0; mark_addr = 5'd0; busW = 32'd0;
        regwr_c = 1'b0; rdst_c = 1'b1; jal_c = 1'b0; mark_c = 1'b0;
        rs_c = 4'd0; rt_c = 4'd0; rd_c = 4'd0; maddr_c = 4'd0; busw_c = 64'd0;

        tick(); tick();
        reset = 1'b0;
        push2(cyc, 0, 0, 64'd0, 64'd0, "rst_busA");
        push2(cyc, 1, 0, 64'd0, 64'd0, "rst_busB");
        push2(cyc, 4, 0, 64'd0, 64'd0, "rst_busy_vec");
        push2(cyc, 2, 0, 64'd0, 64'd0, "rst_stall");

        // reset test: load r5 (visible on both buses) and a busy bit, then reset mid-cycle
        tick(); regWr = 1'b1; Rd = 5'd5; busW = 32'hDEADBEEF; Rs = 5'd5; Rt = 5'd5;
        mark_busy = 1'b1; mark_addr = 5'd2;
        push(cyc + 1, 0, 0, 0, 64'hDEADBEEF, "pre_rst_busA");
        tick(); Rs = 5'd5; Rt = 5'd5;
        push(cyc, 0, 3, 2, 64'd1, "pre_rst_busy2");
        push(cyc, 1, 0, 0, 64'd0, "pre_rst_nobyp_busA");
        tick(); reset = 1'b1; Rs = 5'd2;
        push2(cyc, 0, 0, 64'd0, 64'd0, "async_rst_busA");
        push2(cyc, 1, 0, 64'd0, 64'd0, "async_rst_busB");
        push2(cyc, 4, 0, 64'd0, 64'd0, "async_rst_busy_vec");
        push2(cyc, 2, 0, 64'd0, 64'd0, "async_rst_stall");
        tick();
        tick(); reset = 1'b0; Rs = 5'd5;
        push2(cyc + 1, 0, 0, 64'd0, 64'd0, "post_rst_r5");

        // destination select and zero register
        tick(); regWr = 1'b1; Rdst = 1'b1; Rd = 5'd3; Rt = 5'd8; busW = 32'h11;
        tick(); regWr = 1'b1; Rdst = 1'b0; Rd = 5'd3; Rt = 5'd4; busW = 32'h22;
        tick(); regWr = 1'b1; jal_instr = 1'b1; Rdst = 1'b1; Rd = 5'd3; Rt = 5'd4; busW = 32'h400;
        tick(); regWr = 1'b1; Rd = 5'd0; busW = 32'hFF;
        tick(); Rs = 5'd3; Rt = 5'd4;
        push2(cyc + 1, 0, 0, 64'h11, 64'h11, "dst_rd_r3");
        push2(cyc + 1, 1, 0, 64'h22, 64'h22, "dst_rt_r4");
        tick(); Rs = 5'd31; Rt = 5'd0;
        push2(cyc + 1, 0, 0, 64'h400, 64'h400, "dst_jal_r31");
        push2(cyc + 1, 1, 0, 64'd0, 64'd0, "zero_r0");
        tick(); Rs = 5'd8;
        push2(cyc + 1, 0, 0, 64'd0, 64'd0, "dst_rt_unused_r8");

        // bypass versus no bypass
        tick(); regWr = 1'b1; Rd = 5'd7; busW = 32'h77;
        tick(); regWr = 1'b1; Rd = 5'd7; busW = 32'hCAFE0001; Rs = 5'd7;
        push2(cyc + 1, 0, 0, 64'hCAFE0001, 64'h77, "byp_same_cycle");
        tick(); Rs = 5'd7;
        push2(cyc + 1, 0, 0, 64'hCAFE0001, 64'hCAFE0001, "byp_next_cycle");

        // scoreboard on port A
        tick(); mark_busy = 1'b1; mark_addr = 5'd9;
        tick(); Rs = 5'd9;
        push2(cyc, 2, 0, 64'd1, 64'd1, "sb_stall_rs");
        push2(cyc, 3, 9, 64'd1, 64'd1, "sb_busy9_set");
        tick(); regWr = 1'b1; Rd = 5'd9; busW = 32'h99; Rs = 5'd9;
        push2(cyc, 2, 0, 64'd0, 64'd1, "sb_stall_wr");
        tick(); Rs = 5'd9;
        push2(cyc, 3, 9, 64'd0, 64'd0, "sb_busy9_clr");
        push2(cyc, 2, 0, 64'd0, 64'd0, "sb_stall_after");

        // scoreboard on port B
        tick(); mark_busy = 1'b1; mark_addr = 5'd12;
        tick(); Rt = 5'd12;
        push2(cyc, 2, 0, 64'd1, 64'd1, "sb_stall_rt");
        tick(); regWr = 1'b1; Rd = 5'd12; busW = 32'h12;

        // set/clear collision
        tick(); mark_busy = 1'b1; mark_addr = 5'd6; regWr = 1'b1; Rd = 5'd6; busW = 32'h66;
        tick(); Rs = 5'd6;
        push2(cyc, 3, 6, 64'd1, 64'd1, "coll_busy6");
        push2(cyc, 2, 0, 64'd1, 64'd1, "coll_stall");
        push2(cyc + 1, 0, 0, 64'h66, 64'h66, "coll_data");

        // marking r0 is ignored
        tick(); mark_busy = 1'b1; mark_addr = 5'd0;
        tick();
        push2(cyc, 3, 0, 64'd0, 64'd0, "zero_never_busy");

        // back-to-back writes, last one wins
        tick(); regWr = 1'b1; Rd = 5'd10; busW = 32'h1;
        tick(); regWr = 1'b1; Rd = 5'd10; busW = 32'h2;
        tick(); Rs = 5'd10; Rt = 5'd10;
        push2(cyc + 1, 0, 0, 64'h2, 64'h2, "b2b_busA");
        push2(cyc + 1, 1, 0, 64'h2, 64'h2, "b2b_busB");

        // 64-bit x 16 sweep
        for (int i = 1; i < 16; i++) begin
            tick(); regwr_c = 1'b1; rd_c = 4'(i); busw_c = 64'h0123456789ABCDEF;
        end
        for (int i = 1; i < 16; i++) begin
            tick(); rs_c = 4'(i); rt_c = 4'(i);
            push(cyc + 1, 2, 0, 0, 64'h0123456789ABCDEF, $sformatf("sweep_busA_r%0d", i));
            push(cyc + 1, 2, 1, 0, 64'h0123456789ABCDEF, $sformatf("sweep_busB_r%0d", i));
        end
        tick();
        push(cyc, 2, 4, 0, 64'd0, "sweep_busy_vec");
        tick(); regwr_c = 1'b1; jal_c = 1'b1; rd_c = 4'd3; rt_c = 4'd4; busw_c = 64'hFEDC0000000000AA;
        tick(); rs_c = 4'd15; rt_c = 4'd3;
        push(cyc + 1, 2, 0, 0, 64'hFEDC0000000000AA, "sweep_jal_r15");
        push(cyc + 1, 2, 1, 0, 64'h0123456789ABCDEF, "sweep_r3_kept");

        repeat (3) tick();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_file_sb.md
# gpr_file_sb

Parametrised general-purpose register file with two registered read ports, one write port, destination-select logic, optional write-to-read bypass and a per-register busy scoreboard. It is the next-generation GPR file for the processor core. It sits between decode and writeback:
- decode presents source and destination fields and receives operand buses plus a hazard stall;
- writeback presents the result bus and write enable.

## Interface
Parameters:
- DATA_W, 32: register and bus width in bits.
- ADDR_W, 5: register address width; the file holds 2**ADDR_W registers.
- LINK_REG, 2**ADDR_W-1: destination register forced by jal_instr.
- ZERO_REG_EN, 1: when 1, register 0 reads as 0, ignores writes and is never busy.
- BYPASS_EN, 1: when 1, a same-cycle write is forwarded to a read of the same address.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- regWr, input, 1: write enable for busW into the selected destination.
- Rs, input, ADDR_W: read address, port A.
- Rt, input, ADDR_W: read address, port B, and alternate destination.
- Rd, input, ADDR_W: primary destination.
- Rdst, input, 1: destination select, 0 = Rt, 1 = Rd.
- jal_instr, input, 1: forces destination to LINK_REG; overrides Rdst.
- busW, input, DATA_W: write data.
- mark_busy, input, 1: marks mark_addr as awaiting a pending result.
- mark_addr, input, ADDR_W: register to mark busy.
- busA, output, DATA_W: registered read data, port A.
- busB, output, DATA_W: registered read data, port B.
- stall, output, 1: combinational hazard flag for the current Rs/Rt.
- busy_vec, output, 2**ADDR_W: current scoreboard bits, for debug.

## Operation
- Destination: Rw = jal_instr ? LINK_REG : (Rdst ? Rd : Rt). This is combinational from the same-cycle inputs.
- Write: on a clock edge with regWr=1, regFile[Rw] <= busW. When ZERO_REG_EN=1 and Rw=0, the write is dropped.
- Read: on every clock edge, busA <= value(Rs) and busB <= value(Rt).
- value(x):
  - 0 when ZERO_REG_EN=1 and x=0;
  - otherwise busW when BYPASS_EN=1, regWr=1 and Rw=x;
  - otherwise regFile[x], the pre-edge contents.
- With BYPASS_EN=0, a same-cycle read returns the old contents. The new value is visible one edge later.
- Scoreboard, one busy bit per register:
  - set: mark_busy=1 sets busy[mark_addr];
  - clear: a performed write (regWr=1 and not dropped) clears busy[Rw];
  - same address set and clear in one edge: set wins, i.e. a new pending producer;
  - ZERO_REG_EN=1: mark_busy with mark_addr=0 is ignored.
- Stall: stall = hzd(Rs) | hzd(Rt), where hzd(x) = busy[x] & !(BYPASS_EN & regWr & Rw==x).
- Stall does not gate writes or reads; the pipeline controller uses it to hold decode.
- Reset (asynchronous):
  - all registers, busA, busB and busy_vec go to 0 immediately; stall goes to 0;
  - the state holds while reset=1;
  - a write or mark coinciding with reset is lost.

## Timing
- Read latency: 1 cycle. Inputs Rs/Rt at edge N appear on busA/busB after edge N.
- Write-to-read latency:
  - 0 extra cycles with bypass, because a read sampled at the write edge returns busW;
  - 1 extra cycle without bypass.
- stall depends combinationally on Rs, Rt, regWr, Rw and registered busy. There is no flop in the path.
- mark_busy at edge N makes stall visible for a matching Rs/Rt after edge N.
- Reset deassertion: the first functional edge is the first rising clk edge with reset low. Reset deassertion is synchronised externally.
- Back-to-back writes to the same register on consecutive edges: the last one wins; each clears busy.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert reset mid-cycle. Required: busA, busB and busy_vec are 0 immediately. After release, Rs=5 reads 0x00000000.
- Destination select and zero register:
  - Rdst=1, Rd=3, busW=0x11 writes r3;
  - Rdst=0, Rt=4, busW=0x22 writes r4;
  - jal_instr=1, busW=0x400 writes r31 regardless of Rd and Rt;
  - a write of 0xFF to r0 reads back 0.
- Bypass: regWr=1, Rd=7, busW=0xCAFE0001 with Rs=7 in the same cycle. Required: busA=0xCAFE0001 after that edge. With BYPASS_EN=0, busA shows the old r7 value, then 0xCAFE0001 one cycle later.
- Scoreboard:
  - mark_busy with mark_addr=9, then Rs=9: stall=1;
  - a write to r9 in the same cycle as Rs=9 with BYPASS_EN=1: stall=0;
  - after that write, busy_vec[9]=0.
- Set/clear collision: mark_busy with mark_addr=6 and a write to r6 on the same edge. Required: busy_vec[6]=1 and r6 holds the written data.
- Width/depth sweep: DATA_W=64, ADDR_W=4, LINK_REG=15. Write 0x0123456789ABCDEF to each of r1–r15, then read all back through both ports. Required: an exact match on every register and busy_vec all zeros.
